// File: rtl/inst_loader.sv
// UART-fed instruction loader: receives 8N1 bytes, packs them MSB-first into
// 32-bit words and writes them sequentially into instruction memory.
module inst_loader #(
  parameter int CLK_PER_HALF_BIT = 434,
  parameter int INST_SIZE        = 10
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 rxd,
  input  logic                 mode,
  output logic                 we,
  output logic [INST_SIZE-1:0] addr,
  output logic [31:0]          wdata,
  output logic                 done,
  output logic [INST_SIZE:0]   word_count,
  output logic                 ferr,
  output logic                 ovf
);

  localparam int TW = $clog2(2*CLK_PER_HALF_BIT + 1);
  localparam logic [TW-1:0]        HALF_END  = TW'(CLK_PER_HALF_BIT - 1);
  localparam logic [TW-1:0]        BIT_END   = TW'(2*CLK_PER_HALF_BIT - 1);
  localparam logic [INST_SIZE:0]   FULL_CNT  = {1'b1, {INST_SIZE{1'b0}}};
  localparam logic [INST_SIZE-1:0] LAST_ADDR = '1;
  localparam logic [31:0]          TERM_WORD = 32'h0000_003F;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rxd_p0;
  logic            rxd_p1;
  logic            armed;
  logic [TW-1:0]   timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic [1:0]      byte_idx;
  logic            we_q;
  logic            run;
  logic            timer_clr;
  logic            bit_smp;
  logic            stop_ok;
  logic            stop_bad;

  function automatic logic [31:0] place_byte(input logic [31:0] word,
                                             input logic [7:0]  b,
                                             input logic [1:0]  idx);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

  assign run = mode & ~done & ~ovf;
  assign we  = we_q & run;

  // stage p0/p1: two-flop synchronizer; armed blocks a start bit until the
  // line has been seen idle-high after reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rxd_p0 <= 1'b0;
      rxd_p1 <= 1'b0;
      armed  <= 1'b0;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      if (rxd_p1)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    timer_clr = 1'b0;
    bit_smp   = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    if (!run) begin
      state_nxt = IDLE;
      timer_clr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          timer_clr = 1'b1;
          if (armed && !rxd_p1)
            state_nxt = START;
        end
        START: begin
          if (timer == HALF_END) begin
            timer_clr = 1'b1;
            state_nxt = rxd_p1 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (timer == BIT_END) begin
            timer_clr = 1'b1;
            bit_smp   = 1'b1;
            if (bit_idx == 3'd7)
              state_nxt = STOP;
          end
        end
        STOP: begin
          if (timer == BIT_END) begin
            timer_clr = 1'b1;
            state_nxt = IDLE;
            stop_ok   = rxd_p1;
            stop_bad  = ~rxd_p1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      if (timer_clr)
        timer <= '0;
      else
        timer <= timer + 1'b1;
      if (state == START)
        bit_idx <= '0;
      else if (bit_smp)
        bit_idx <= bit_idx + 1'b1;
    end
  end

  // data bits arrive LSB first, so shift in from the top
  always_ff @(posedge clk) begin
    if (bit_smp)
      shreg <= {rxd_p1, shreg[7:1]};
  end

  // stage p2: byte commit, word write strobe and address bookkeeping
  always_ff @(posedge clk) begin
    if (!rstn) begin
      byte_idx   <= '0;
      we_q       <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      done       <= 1'b0;
      word_count <= '0;
      ferr       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (!mode)
        byte_idx <= '0;
      if (stop_bad)
        ferr <= 1'b1;
      if (stop_ok) begin
        wdata    <= place_byte(wdata, shreg, byte_idx);
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          if (word_count == FULL_CNT)
            ovf <= 1'b1;
          else
            we_q <= 1'b1;
        end
      end
      if (we) begin
        word_count <= word_count + 1'b1;
        if (addr != LAST_ADDR)
          addr <= addr + 1'b1;
        if (wdata == TERM_WORD)
          done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized and directed bench for inst_loader against a byte-level model
// of the loader's word assembly, write sequencing and sticky flags.
module tb_inst_loader;

  localparam int HALF  = 8;
  localparam int ISZ   = 2;
  localparam int DEPTH = 1 << ISZ;

  logic           clk = 1'b0;
  logic           rstn;
  logic           rxd;
  logic           mode;
  logic           we;
  logic [ISZ-1:0] addr;
  logic [31:0]    wdata;
  logic           done;
  logic [ISZ:0]   word_count;
  logic           ferr;
  logic           ovf;

  inst_loader #(.CLK_PER_HALF_BIT(HALF), .INST_SIZE(ISZ)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rxd        (rxd),
    .mode       (mode),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .done       (done),
    .word_count (word_count),
    .ferr       (ferr),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: one entry per byte, expected writes queued in order
  typedef struct packed {
    logic [ISZ-1:0] a;
    logic [31:0]    d;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_e;
  int          m_idx;
  int          m_cnt;
  int          m_addr;
  logic [31:0] m_word;
  bit          m_done;
  bit          m_ovf;
  bit          m_ferr;
  bit          we_prev = 1'b0;

  task automatic model_reset();
    m_idx  = 0;
    m_cnt  = 0;
    m_addr = 0;
    m_word = '0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    wr_t w;
    if (!mode || m_done || m_ovf) return;
    if (!stop_ok) begin
      m_ferr = 1'b1;
      return;
    end
    m_word[31-8*m_idx -: 8] = b;
    if (m_idx == 3) begin
      m_idx = 0;
      if (m_cnt == DEPTH) begin
        m_ovf = 1'b1;
      end else begin
        w.a = ISZ'(m_addr);
        w.d = m_word;
        exp_q.push_back(w);
        m_cnt++;
        if (m_word == 32'h0000_003F) m_done = 1'b1;
        if (m_addr < DEPTH - 1) m_addr++;
      end
    end else begin
      m_idx++;
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      check("we_width", {63'd0, we_prev}, 64'd0);
      check("we_mode", {63'd0, mode}, 64'd1);
      if (exp_q.size() == 0) begin
        check("we_unexpected", {63'd0, we}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 64'(addr), 64'(mon_e.a));
        check("we_data", 64'(wdata), 64'(mon_e.d));
      end
    end
    we_prev = we;
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    model_byte(b, stop_ok);
    @(negedge clk);
    rxd = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (2*HALF) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (2*HALF) @(negedge clk);
    rxd = 1'b1;
    repeat (2*HALF) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--)
      send_byte(w[8*i +: 8], 1'b1);
  endtask

  task automatic partial_frame(input int nbits);
    @(negedge clk);
    rxd = 1'b0;
    repeat (2*HALF) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      rxd = 1'($urandom_range(0, 1));
      repeat (2*HALF) @(negedge clk);
    end
  endtask

  task automatic mode_pause(input int cyc);
    @(negedge clk);
    mode  = 1'b0;
    m_idx = 0;
    repeat (cyc) @(negedge clk);
    rxd = 1'b1;
    repeat (2*HALF) @(negedge clk);
    mode = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    rxd  = 1'b1;
    repeat (3) @(negedge clk);
    model_reset();
    rstn = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    64'(we),         64'd0);
    check({tag, "_addr"},  64'(addr),       64'd0);
    check({tag, "_wdata"}, 64'(wdata),      64'd0);
    check({tag, "_done"},  64'(done),       64'd0);
    check({tag, "_count"}, 64'(word_count), 64'd0);
    check({tag, "_ferr"},  64'(ferr),       64'd0);
    check({tag, "_ovf"},   64'(ovf),        64'd0);
  endtask

  task automatic check_state(input string tag);
    repeat (4) @(negedge clk);
    check({tag, "_done"},    64'(done),         64'(m_done));
    check({tag, "_ovf"},     64'(ovf),          64'(m_ovf));
    check({tag, "_ferr"},    64'(ferr),         64'(m_ferr));
    check({tag, "_count"},   64'(word_count),   64'(m_cnt));
    check({tag, "_addr"},    64'(addr),         64'(m_addr));
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int          n;
    int          act;
    rstn = 1'b0;
    rxd  = 1'b1;
    mode = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check_reset_outputs("rst");
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // two words, the second being the terminator; later bytes are ignored
    mode = 1'b1;
    send_word(32'h1234_5678);
    send_word(32'h0000_003F);
    check_state("term");
    send_word(32'hCAFE_F00D);
    check_state("after_done");

    // short low glitch produces nothing, then a normal word
    do_reset();
    mode = 1'b1;
    @(negedge clk);
    rxd = 1'b0;
    repeat (HALF/2) @(negedge clk);
    rxd = 1'b1;
    repeat (4*HALF) @(negedge clk);
    check_state("glitch");
    send_word(32'hAABB_CCDD);
    check_state("glitch_word");

    // framing error between bytes does not advance the word
    do_reset();
    mode = 1'b1;
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    check_state("ferr");

    // mode drop mid-word and mid-byte discards the partial word
    do_reset();
    mode = 1'b1;
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    mode_pause(20);
    send_word(32'hDEAD_BEEF);
    send_byte(8'h77, 1'b1);
    partial_frame(3);
    mode_pause(5);
    send_word(32'h0BAD_F00D);
    check_state("mode");

    // fill the memory, then one more word overflows
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 5; k++) begin
      w = $urandom();
      if (w == 32'h0000_003F) w = 32'h1;
      send_word(w);
    end
    check_state("ovf");

    // reset in the middle of the second word, line held low across release
    do_reset();
    mode = 1'b1;
    send_word(32'h1122_3344);
    send_byte(8'h99, 1'b1);
    partial_frame(4);
    rxd  = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("midrst");
    model_reset();
    rstn = 1'b1;
    repeat (6*HALF) @(negedge clk);
    rxd = 1'b1;
    repeat (2*HALF) @(negedge clk);
    check_state("midrst_idle");
    send_word(32'h5566_7788);
    check_state("midrst_word");

    // randomized byte streams with framing errors, pauses and terminators
    for (int it = 0; it < 5; it++) begin
      do_reset();
      mode = 1'b1;
      n = $urandom_range(10, 28);
      for (int b = 0; b < n; b++) begin
        act = $urandom_range(0, 99);
        if (act < 80)
          send_byte(8'($urandom()), ($urandom_range(0, 9) != 0));
        else if (act < 86)
          send_word(32'h0000_003F);
        else if (act < 93)
          mode_pause($urandom_range(1, 30));
        else begin
          partial_frame($urandom_range(1, 7));
          mode_pause($urandom_range(1, 10));
        end
      end
      check_state("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
